// File: rtl/cpu_periph_pkg.sv
// cpu_periph_pkg: address map and register bit positions shared by the MMIO block.
package cpu_periph_pkg;
    localparam logic [31:0] TMR_BASE       = 32'h4000_0000;
    localparam logic [3:0]  TMR_TH         = 4'h0;
    localparam logic [3:0]  TMR_TL         = 4'h4;
    localparam logic [3:0]  TMR_TCON       = 4'h8;
    localparam logic [31:0] LED_ADDR       = 32'h4000_0100;
    localparam logic [31:0] DIG_ADDR       = 32'h4000_0104;
    localparam logic [31:0] UART_TXD_ADDR  = 32'h4000_0200;
    localparam logic [31:0] UART_RXD_ADDR  = 32'h4000_0204;
    localparam logic [31:0] UART_CON_ADDR  = 32'h4000_0208;
    localparam logic [31:0] UART_STAT_ADDR = 32'h4000_020C;
    localparam int TCON_EN    = 0;
    localparam int TCON_IEN   = 1;
    localparam int TCON_STAT  = 2;
    localparam int CON_TX_IEN = 0;
    localparam int CON_RX_IEN = 1;
    localparam int STAT_OVF   = 3;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive FIFO with simultaneous push/pop support even when full.
// Ports: clk, reset (async active-low), push/din write side, pop/dout read side (dout = head),
//        full/empty status.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp_q, wp_d, rp_q, rp_d;
    logic do_push, do_pop;
    assign empty   = wp_q == rp_q;
    assign full    = wp_q == {~rp_q[AW], rp_q[AW-1:0]};
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot the push lands in
    assign do_push = push && (!full || do_pop);
    assign wp_d    = do_push ? wp_q + 1'b1 : wp_q;
    assign rp_d    = do_pop ? rp_q + 1'b1 : rp_q;
    assign dout    = mem[rp_q[AW-1:0]];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/cpu_periph_bus.sv
// cpu_periph_bus: MEM-stage data RAM plus MMIO timers, LED/7-seg, UART TX/RX FIFO and IRQ.
// Ports: clk, reset (async active-low); Addr/WriteData/MemRd/MemWr CPU bus, ReadData load data
//        (0 unless MemRd); IRQ level interrupt; led/AN/digital display registers;
//        UART_TXD/TX_EN/TX_STATUS transmit side; RX_DATA/RX_STATUS receive side.
module cpu_periph_bus
    import cpu_periph_pkg::*;
#(
    parameter int          RAM_WORDS  = 256,
    parameter int          NUM_TIMERS = 2,
    parameter int          RX_DEPTH   = 8,
    parameter logic [31:0] TH_RST     = 32'hFFFF_F800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemRd,
    input  logic        MemWr,
    output logic [31:0] ReadData,
    output logic        IRQ,
    output logic [7:0]  led,
    output logic [3:0]  AN,
    output logic [7:0]  digital,
    output logic [7:0]  UART_TXD,
    output logic        TX_EN,
    input  logic        TX_STATUS,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_STATUS
);
    localparam int RA = $clog2(RAM_WORDS);
    localparam logic [2:0] NT = 3'(NUM_TIMERS);
    logic [31:0] ram [RAM_WORDS];
    logic ram_hit, tmr_blk;
    logic [3:0][31:0] th_v, tl_v;
    logic [3:0][2:0] tcon_v;
    logic [3:0] tmr_irq;
    logic [7:0] led_q, led_d, dig_q, dig_d, txd_q, txd_d, rx_dout;
    logic [3:0] an_q, an_d;
    logic [1:0] con_q, con_d;
    logic ovf_q, ovf_d, tx_en_q, tx_go, rx_sts_q, rx_push, rx_pop, rx_full, rx_empty;
    logic [31:0] rd;
    assign ram_hit = Addr[31:RA+2] == '0 && Addr[1:0] == 2'b00;
    assign tmr_blk = Addr[31:6] == TMR_BASE[31:6] && {1'b0, Addr[5:4]} < NT;
    for (genvar t = 0; t < 4; t++) begin : g_tmr
        if (t < NUM_TIMERS) begin : g_on
            logic [31:0] th_q, th_d, tl_q, tl_d;
            logic [2:0] tcon_q, tcon_d;
            logic sel, ovf;
            assign sel = MemWr && tmr_blk && Addr[5:4] == 2'(t);
            assign ovf = tcon_q[TCON_EN] && tl_q == '1;
            always_comb begin
                th_d = sel && Addr[3:0] == TMR_TH ? WriteData : th_q;
                tl_d = sel && Addr[3:0] == TMR_TL ? WriteData
                     : !tcon_q[TCON_EN] ? tl_q
                     : ovf ? th_q : tl_q + 32'd1;
                tcon_d = sel && Addr[3:0] == TMR_TCON ? WriteData[2:0] : tcon_q;
                // an overflow in the same cycle as a clearing write keeps stat set
                tcon_d[TCON_STAT] = tcon_d[TCON_STAT] | ovf;
            end
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    th_q   <= TH_RST;
                    tl_q   <= TH_RST;
                    tcon_q <= '0;
                end else begin
                    th_q   <= th_d;
                    tl_q   <= tl_d;
                    tcon_q <= tcon_d;
                end
            end
            assign th_v[t]    = th_q;
            assign tl_v[t]    = tl_q;
            assign tcon_v[t]  = tcon_q;
            assign tmr_irq[t] = tcon_q[TCON_STAT] & tcon_q[TCON_IEN];
        end else begin : g_off
            assign th_v[t]    = '0;
            assign tl_v[t]    = '0;
            assign tcon_v[t]  = '0;
            assign tmr_irq[t] = 1'b0;
        end
    end
    assign rx_push = RX_STATUS && !rx_sts_q;
    assign rx_pop  = MemRd && Addr == UART_RXD_ADDR;
    uart_rx_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .din   (RX_DATA),
        .pop   (rx_pop),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );
    always_comb begin
        led_d = MemWr && Addr == LED_ADDR ? WriteData[7:0] : led_q;
        an_d  = MemWr && Addr == DIG_ADDR ? WriteData[11:8] : an_q;
        dig_d = MemWr && Addr == DIG_ADDR ? WriteData[7:0] : dig_q;
        con_d = MemWr && Addr == UART_CON_ADDR ? WriteData[1:0] : con_q;
        tx_go = MemWr && Addr == UART_TXD_ADDR && TX_STATUS;
        txd_d = tx_go ? WriteData[7:0] : txd_q;
        // full implies non-empty, so rx_pop here is always an effective pop
        ovf_d = rx_push && rx_full && !rx_pop ? 1'b1
              : MemWr && Addr == UART_STAT_ADDR && WriteData[STAT_OVF] ? 1'b0 : ovf_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q    <= '0;
            an_q     <= 4'hF;
            dig_q    <= 8'hFF;
            con_q    <= '0;
            txd_q    <= '0;
            tx_en_q  <= 1'b0;
            ovf_q    <= 1'b0;
            rx_sts_q <= 1'b0;
        end else begin
            led_q    <= led_d;
            an_q     <= an_d;
            dig_q    <= dig_d;
            con_q    <= con_d;
            txd_q    <= txd_d;
            tx_en_q  <= tx_go;
            ovf_q    <= ovf_d;
            rx_sts_q <= RX_STATUS;
        end
    end
    always_ff @(posedge clk) begin
        if (MemWr && ram_hit) ram[Addr[RA+1:2]] <= WriteData;
    end
    always_comb begin
        rd = '0;
        case (Addr)
            LED_ADDR:       rd = {24'b0, led_q};
            DIG_ADDR:       rd = {20'b0, an_q, dig_q};
            UART_TXD_ADDR:  rd = {24'b0, txd_q};
            UART_RXD_ADDR:  rd = {24'b0, rx_empty ? 8'h00 : rx_dout};
            UART_CON_ADDR:  rd = {30'b0, con_q};
            UART_STAT_ADDR: rd = {28'b0, ovf_q, rx_full, rx_empty, TX_STATUS};
            default: rd = ram_hit ? ram[Addr[RA+1:2]]
                        : !tmr_blk ? '0
                        : Addr[3:0] == TMR_TH ? th_v[Addr[5:4]]
                        : Addr[3:0] == TMR_TL ? tl_v[Addr[5:4]]
                        : Addr[3:0] == TMR_TCON ? {29'b0, tcon_v[Addr[5:4]]} : '0;
        endcase
    end
    assign ReadData = MemRd ? rd : '0;
    assign IRQ      = |tmr_irq | (con_q[CON_RX_IEN] & ~rx_empty) | (con_q[CON_TX_IEN] & TX_STATUS);
    assign led      = led_q;
    assign AN       = an_q;
    assign digital  = dig_q;
    assign UART_TXD = txd_q;
    assign TX_EN    = tx_en_q;
endmodule
